axi_tile_skew_loader: RTL and testbench

Parametrised AXI4 read master that fetches a runtime-sized matrix tile (rows × cols words) from memory and writes it into a local tile buffer through a simple write port. Optional modes place the tile row-major, transposed, and/or diagonally skewed with zero bubbles, ready for systolic-array feeding. It is the generalised successor to the fixed-shape matrix receive logic: any shape up to the parameter limits, strided rows, explicit response/last checking, and a buffer port instead of wide register arrays.

---
 rtl/axi_tile_skew_loader.sv | 196 +++++++++++++++++++
 tb/tb_axi_tile_skew_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tile_skew_loader.sv
// AXI4 read master that fetches a rows x cols tile (one INCR burst per row) and
// places it into a tile buffer in plain, transposed and/or bubble-free skewed layout.
module axi_tile_skew_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_ROWS = 32,
  parameter int MAX_COLS = 32,
  parameter int BUF_AW   = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [8:0]        cfg_rows,
  input  logic [8:0]        cfg_cols,
  input  logic              cfg_skew,
  input  logic              cfg_transpose,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic [2:0]        axi_arsize,
  output logic [1:0]        axi_arburst,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rlast,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [8:0] MAX_R   = 9'(MAX_ROWS);
  localparam logic [8:0] MAX_C   = 9'(MAX_COLS);

  logic [2:0]        state;
  logic [8:0]        rows, cols, row, beat;
  logic [ADDR_W-1:0] stride;
  logic              skew, transpose, drain;

  logic [8:0]        rows_in, cols_in;
  logic              cfg_bad;
  logic [BUF_AW-1:0] span, clear_last, place_addr;
  logic              last_col, last_row, r_beat;

  // Buffer address of element (r,c); arithmetic wraps at 2^BUF_AW by construction.
  function automatic logic [BUF_AW-1:0] place(input logic [8:0] r, input logic [8:0] c,
                                              input logic [8:0] nr, input logic [8:0] nc,
                                              input logic [BUF_AW-1:0] p,
                                              input logic sk, input logic tr);
    logic [BUF_AW-1:0] major, minor, pitch;
    major = tr ? BUF_AW'(c) : BUF_AW'(r);
    minor = tr ? BUF_AW'(r) : BUF_AW'(c);
    pitch = sk ? p : (tr ? BUF_AW'(nr) : BUF_AW'(nc));
    return major * pitch + minor + (sk ? major : '0);
  endfunction

  always_comb begin
    rows_in = cfg_rows;
    cols_in = cfg_cols;
    cfg_bad = 1'b0;
    if (cfg_rows == 9'd0) begin
      rows_in = 9'd1;
      cfg_bad = 1'b1;
    end else if (cfg_rows > MAX_R) begin
      rows_in = MAX_R;
      cfg_bad = 1'b1;
    end
    if (cfg_cols == 9'd0) begin
      cols_in = 9'd1;
      cfg_bad = 1'b1;
    end else if (cfg_cols > MAX_C) begin
      cols_in = MAX_C;
      cfg_bad = 1'b1;
    end
  end

  assign span       = BUF_AW'(rows) + BUF_AW'(cols) - 1'b1;
  assign clear_last = (transpose ? BUF_AW'(cols) : BUF_AW'(rows)) * span - 1'b1;
  assign place_addr = place(row, beat, rows, cols, span, skew, transpose);
  assign last_col   = (beat == cols - 9'd1);
  assign last_row   = (row == rows - 9'd1);
  assign r_beat     = axi_rvalid & axi_rready;

  assign axi_arsize  = axi_arvalid ? AR_SIZE : 3'd0;
  assign axi_arburst = axi_arvalid ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      rows        <= '0;
      cols        <= '0;
      row         <= '0;
      beat        <= '0;
      stride      <= '0;
      skew        <= 1'b0;
      transpose   <= 1'b0;
      drain       <= 1'b0;
    end else begin
      done   <= 1'b0;
      buf_we <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rows       <= rows_in;
          cols       <= cols_in;
          stride     <= cfg_stride;
          skew       <= cfg_skew;
          transpose  <= cfg_transpose;
          err        <= cfg_bad;
          busy       <= 1'b1;
          axi_araddr <= cfg_base;
          axi_arlen  <= 8'(cols_in - 9'd1);
          row        <= '0;
          beat       <= '0;
          drain      <= 1'b0;
          buf_addr   <= '0;
          buf_wdata  <= '0;
          if (cfg_skew) begin
            buf_we <= 1'b1;
            state  <= ST_CLEAR;
          end else begin
            axi_arvalid <= 1'b1;
            state       <= ST_ADDR;
          end
        end
        // Zero-fill so every bubble slot of the skewed layout reads 0.
        ST_CLEAR: if (buf_addr == clear_last) begin
          axi_arvalid <= 1'b1;
          state       <= ST_ADDR;
        end else begin
          buf_we   <= 1'b1;
          buf_addr <= buf_addr + 1'b1;
        end
        ST_ADDR: if (axi_arready) begin
          axi_arvalid <= 1'b0;
          axi_rready  <= 1'b1;
          state       <= ST_DATA;
        end
        ST_DATA: if (r_beat) begin
          if (axi_rresp != 2'b00) err <= 1'b1;
          // Past the cols-th beat the row is complete; drain until the slave sends rlast.
          if (!drain) begin
            buf_we    <= 1'b1;
            buf_addr  <= place_addr;
            buf_wdata <= axi_rdata;
            beat      <= beat + 9'd1;
            if (axi_rlast != last_col) err <= 1'b1;
            if (last_col && !axi_rlast) drain <= 1'b1;
          end
          if (axi_rlast) begin
            beat       <= '0;
            drain      <= 1'b0;
            axi_rready <= 1'b0;
            if (last_row) begin
              state <= ST_FINISH;
            end else begin
              row         <= row + 9'd1;
              axi_araddr  <= axi_araddr + stride;
              axi_arvalid <= 1'b1;
              state       <= ST_ADDR;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_tile_skew_loader.sv
// Scoreboard bench for axi_tile_skew_loader: AXI slave model returning rdata = byte address,
// expected AR requests and buffer writes queued at stimulus time and popped as the DUT emits them.
module tb_axi_tile_skew_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BUF_AW = 12;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0, cfg_stride = '0;
  logic [8:0]        cfg_rows = '0, cfg_cols = '0;
  logic              cfg_skew = 1'b0, cfg_transpose = 1'b0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] axi_araddr;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_arvalid, axi_rready;
  logic              axi_arready = 1'b0;
  logic [DATA_W-1:0] axi_rdata = '0;
  logic [1:0]        axi_rresp = '0;
  logic              axi_rlast = 1'b0, axi_rvalid = 1'b0;
  logic              buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;

  axi_tile_skew_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ROWS(32), .MAX_COLS(32),
                         .BUF_AW(BUF_AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_skew(cfg_skew), .cfg_transpose(cfg_transpose),
    .busy(busy), .done(done), .err(err), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [BUF_AW-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] len; } ar_t;
  typedef struct { logic [ADDR_W-1:0] a; logic [7:0] len; int row; } burst_t;

  wr_t    wq[$];
  ar_t    arq[$];
  burst_t bq[$];
  logic [DATA_W-1:0] mem [0:4095];
  logic [DATA_W-1:0] mem_ref [0:255];

  // slave behaviour knobs
  bit bp          = 1'b0;
  int f_err_row   = -1, f_err_beat  = -1;
  int f_last_row  = -1, f_last_beat = -1;
  int sb_row      = 0;
  int ar_cnt      = 0;
  int done_cnt    = 0;

  function automatic logic [BUF_AW-1:0] exp_addr(int r, int c, int nr, int nc, bit sk, bit tr);
    int p, a;
    p = nr + nc - 1;
    if (sk && tr)  a = c * p + r + c;
    else if (sk)   a = r * p + c + r;
    else if (tr)   a = c * nr + r;
    else           a = r * nc + c;
    return a[BUF_AW-1:0];
  endfunction

  function automatic int clampv(int v);
    if (v == 0) return 1;
    if (v > 32) return 32;
    return v;
  endfunction

  task automatic prepare(int base, int stride, int rows, int cols, bit sk, bit tr);
    int nr, nc, lines, p;
    wr_t w;
    ar_t e;
    nr = clampv(rows);
    nc = clampv(cols);
    p = nr + nc - 1;
    lines = tr ? nc : nr;
    if (sk)
      for (int i = 0; i < lines * p; i++) begin
        w.a = BUF_AW'(i); w.d = '0; wq.push_back(w);
      end
    for (int r = 0; r < nr; r++) begin
      e.a = ADDR_W'(base + r * stride); e.len = 8'(nc - 1); arq.push_back(e);
      for (int c = 0; c < nc; c++) begin
        if (r == f_last_row && c > f_last_beat) break;
        w.a = exp_addr(r, c, nr, nc, sk, tr);
        w.d = DATA_W'(base + r * stride + c * 4);
        wq.push_back(w);
      end
    end
  endtask

  task automatic kick(int base, int stride, int rows, int cols, bit sk, bit tr);
    sb_row = 0;
    @(posedge clk); #1;
    cfg_base = ADDR_W'(base); cfg_stride = ADDR_W'(stride);
    cfg_rows = 9'(rows); cfg_cols = 9'(cols); cfg_skew = sk; cfg_transpose = tr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_base = '1; cfg_rows = 9'd3; cfg_cols = 9'd5; cfg_skew = ~sk;
  endtask

  task automatic run_load(int base, int stride, int rows, int cols, bit sk, bit tr, bit exp_err);
    int d0, n;
    bit got;
    prepare(base, stride, rows, cols, sk, tr);
    kick(base, stride, rows, cols, sk, tr);
    d0 = done_cnt;
    chk("busy_rise", 64'(busy), 64'(1));
    if (sk) begin
      n = (tr ? clampv(cols) : clampv(rows)) * (clampv(rows) + clampv(cols) - 1);
      for (int i = 0; i < n; i++) begin
        chk("clr_we", 64'(buf_we), 64'(1));
        chk("clr_addr", 64'(buf_addr), 64'(i));
        @(posedge clk); #1;
      end
      chk("clr_end_we", 64'(buf_we), 64'(0));
      chk("clr_end_arvalid", 64'(axi_arvalid), 64'(1));
    end else begin
      chk("first_arvalid", 64'(axi_arvalid), 64'(1));
    end
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      if (done) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) begin
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("err_at_done", 64'(err), 64'(exp_err));
      chk("writes_left", 64'(wq.size()), 64'(0));
      chk("ar_left", 64'(arq.size()), 64'(0));
      @(posedge clk); #1;
      chk("done_pulse_len", 64'(done), 64'(0));
      chk("err_hold", 64'(err), 64'(exp_err));
      chk("done_once", 64'(done_cnt - d0), 64'(1));
    end
  endtask

  // AXI slave: sample what the next edge will see at negedge, respond after that edge.
  logic              s_ar, s_r, s_last, ar_pend;
  logic [ADDR_W-1:0] s_addr, pend_addr;
  logic [7:0]        s_len, pend_len;
  logic [2:0]        s_size;
  logic [1:0]        s_burst;
  int                sbeat = 0;
  burst_t            cur;
  ar_t               ea;
  initial begin
    ar_pend = 1'b0;
    forever begin
      @(negedge clk);
      s_ar = axi_arvalid && axi_arready; s_r = axi_rvalid && axi_rready; s_last = axi_rlast;
      s_addr = axi_araddr; s_len = axi_arlen; s_size = axi_arsize; s_burst = axi_arburst;
      if (rstn && ar_pend) begin
        chk("ar_hold_valid", 64'(axi_arvalid), 64'(1));
        chk("ar_hold_addr", 64'(axi_araddr), 64'(pend_addr));
        chk("ar_hold_len", 64'(axi_arlen), 64'(pend_len));
      end
      ar_pend = rstn && axi_arvalid && !axi_arready;
      pend_addr = axi_araddr; pend_len = axi_arlen;
      @(posedge clk); #1;
      if (!rstn) begin
        bq.delete(); sbeat = 0; ar_pend = 1'b0;
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rresp = 2'b00; axi_arready = 1'b0;
        continue;
      end
      if (s_ar) begin
        cur.a = s_addr; cur.len = s_len; cur.row = sb_row;
        bq.push_back(cur);
        sb_row++; ar_cnt++;
        chk("ar_expected", 64'(arq.size() > 0), 64'(1));
        if (arq.size() > 0) begin
          ea = arq.pop_front();
          chk("araddr", 64'(s_addr), 64'(ea.a));
          chk("arlen", 64'(s_len), 64'(ea.len));
        end
        chk("arsize", 64'(s_size), 64'(2));
        chk("arburst", 64'(s_burst), 64'(1));
      end
      if (s_r) begin
        if (s_last) begin bq.delete(0); sbeat = 0; end
        else sbeat++;
      end
      axi_arready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!(axi_rvalid && !s_r))
        axi_rvalid = (bq.size() > 0) && (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (axi_rvalid) begin
        cur = bq[0];
        axi_rdata = DATA_W'(cur.a + ADDR_W'(sbeat * 4));
        axi_rlast = (cur.row == f_last_row) ? (sbeat == f_last_beat) : (sbeat == int'(cur.len));
        axi_rresp = (cur.row == f_err_row && sbeat == f_err_beat) ? 2'b10 : 2'b00;
      end else begin
        axi_rlast = 1'b0; axi_rresp = 2'b00;
      end
    end
  end

  // Buffer-write and done monitor.
  wr_t ew;
  initial forever begin
    @(negedge clk);
    if (rstn && buf_we) begin
      mem[buf_addr] = buf_wdata;
      chk("write_expected", 64'(wq.size() > 0), 64'(1));
      if (wq.size() > 0) begin
        ew = wq.pop_front();
        chk("buf_addr", 64'(buf_addr), 64'(ew.a));
        chk("buf_wdata", 64'(buf_wdata), 64'(ew.d));
      end
    end
    if (done) done_cnt++;
  end

  int a0, d0;
  bit seen;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_arvalid", 64'(axi_arvalid), 64'(0));
    chk("rst_rready", 64'(axi_rready), 64'(0));
    chk("rst_buf_we", 64'(buf_we), 64'(0));
    chk("rst_araddr", 64'(axi_araddr), 64'(0));
    rstn = 1'b1;

    run_load(32'h1000, 32'h40, 8, 16, 1'b0, 1'b0, 1'b0);
    chk("plain_r3c5", 64'(mem[3*16+5]), 64'(32'h1000 + 32'hC0 + 32'h14));

    for (int i = 0; i < 32; i++) mem[i] = 32'hFFFF_FFFF;
    run_load(32'h2000, 32'h10, 4, 4, 1'b1, 1'b0, 1'b0);
    chk("skew_bubble14", 64'(mem[14]), 64'(0));
    chk("skew_bubble15", 64'(mem[15]), 64'(0));
    chk("skew_bubble20", 64'(mem[20]), 64'(0));
    for (int c = 0; c < 4; c++) chk("skew_row2", 64'(mem[16+c]), 64'(32'h2020 + c * 4));

    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFF_FFFF;
    run_load(32'h3000, 32'h100, 2, 3, 1'b1, 1'b1, 1'b0);
    chk("skewtr_e12", 64'(mem[11]), 64'(32'h3108));

    run_load(32'h4000, 32'h40, 16, 16, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin mem_ref[i] = mem[i]; mem[i] = 32'hDEAD_BEEF; end
    bp = 1'b1;
    run_load(32'h4000, 32'h40, 16, 16, 1'b0, 1'b0, 1'b0);
    bp = 1'b0;
    for (int i = 0; i < 256; i++) chk("bp_vs_zero_wait", 64'(mem[i]), 64'(mem_ref[i]));

    f_err_row = 3; f_err_beat = 5;
    run_load(32'h5000, 32'h20, 8, 8, 1'b0, 1'b0, 1'b1);
    f_err_row = -1; f_err_beat = -1;
    run_load(32'h5000, 32'h20, 8, 8, 1'b0, 1'b0, 1'b0);

    run_load(32'h7000, 32'h80, 0, 40, 1'b0, 1'b0, 1'b1);

    // early rlast on row 0, then reset in the middle of row 1
    f_last_row = 0; f_last_beat = 2;
    prepare(32'h6000, 32'h40, 4, 8, 1'b0, 1'b0);
    a0 = ar_cnt;
    kick(32'h6000, 32'h40, 4, 8, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (ar_cnt - a0 >= 2) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("row1_issued", 64'(seen), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("early_rlast_err", 64'(err), 64'(1));
    chk("midrow_busy", 64'(busy), 64'(1));
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_arvalid", 64'(axi_arvalid), 64'(0));
    chk("arst_rready", 64'(axi_rready), 64'(0));
    chk("arst_buf_we", 64'(buf_we), 64'(0));
    chk("arst_buf_addr", 64'(buf_addr), 64'(0));
    chk("arst_araddr", 64'(axi_araddr), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wq.delete(); arq.delete();
    f_last_row = -1; f_last_beat = -1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));

    run_load(32'h8000, 32'h8, 2, 2, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
